// File: rtl/ahb_lite_matrix.sv
// AHB-lite interconnect: round-robin arbitration over N masters,
// mask/base address decode to M slaves, error and timeout responses.
module ahb_lite_matrix #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
    {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK =
    {32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_MASTERS-1:0]           m_hbusreq,
  input  logic [NUM_MASTERS-1:0]           m_hvalid,
  input  logic [NUM_MASTERS-1:0]           m_hwrite,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata,
  output logic [NUM_MASTERS-1:0]           m_hgrant,
  output logic [DATA_WIDTH-1:0]            m_hrdata,
  output logic                             m_hready,
  output logic                             m_hresp,
  output logic [ADDR_WIDTH-1:0]            s_haddr,
  output logic                             s_hwrite,
  output logic [DATA_WIDTH-1:0]            s_hwdata,
  output logic [NUM_SLAVES-1:0]            s_hsel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata,
  input  logic [NUM_SLAVES-1:0]            s_hready,
  input  logic [NUM_SLAVES-1:0]            s_hresp
);

  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, ERR1, ERR2
  } state_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant;
  logic [LW-1:0]          last;
  logic [SW-1:0]          sidx;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;

  logic [ADDR_WIDTH-1:0] maddr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] mwdat [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] srdat [NUM_SLAVES];

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      maddr[i] = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      mwdat[i] = m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      srdat[i] = s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Nearest requester after last wins: scan far-to-near, keep the last hit.
  logic          any_req;
  logic [LW-1:0] nxt;

  always_comb begin
    int idx;
    idx     = 0;
    nxt     = last;
    any_req = 1'b0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (m_hbusreq[idx]) begin
        nxt     = LW'(idx);
        any_req = 1'b1;
      end
    end
  end

  logic [ADDR_WIDTH-1:0] ga;
  logic                  hit;
  logic [SW-1:0]         didx;
  logic [NUM_SLAVES-1:0] dsel;

  assign ga = maddr[last];

  always_comb begin
    hit  = 1'b0;
    didx = '0;
    dsel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((ga & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit  = 1'b1;
        didx = SW'(i);
        dsel = NUM_SLAVES'(1) << i;
      end
    end
  end

  logic sready;
  logic sresp;

  assign sready   = s_hready[sidx];
  assign sresp    = s_hresp[sidx];
  assign cnt_nxt  = cnt + 1'b1;
  assign m_hgrant = grant;

  always_comb begin
    m_hready = 1'b0;
    m_hresp  = 1'b0;
    m_hrdata = '0;
    s_hwdata = '0;
    unique case (state)
      DATA: begin
        m_hrdata = srdat[sidx];
        s_hwdata = mwdat[last];
        m_hready = sready;
        m_hresp  = sready & sresp;
      end
      ERR1: m_hresp = 1'b1;
      ERR2: begin
        m_hready = 1'b1;
        m_hresp  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= LW'(NUM_MASTERS - 1);
      sidx     <= '0;
      cnt      <= '0;
      s_haddr  <= '0;
      s_hwrite <= 1'b0;
      s_hsel   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant <= NUM_MASTERS'(1) << nxt;
            last  <= nxt;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (!m_hbusreq[last]) begin
            grant <= '0;
            state <= IDLE;
          end else if (m_hvalid[last]) begin
            if (hit) begin
              s_haddr  <= ga;
              s_hwrite <= m_hwrite[last];
              s_hsel   <= dsel;
              sidx     <= didx;
              cnt      <= '0;
              state    <= DATA;
            end else begin
              state <= ERR1;
            end
          end
        end
        DATA: begin
          if (sready) begin
            s_hsel   <= '0;
            s_haddr  <= '0;
            s_hwrite <= 1'b0;
            grant    <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt_nxt;
            if (TIMEOUT != 0 && cnt_nxt == TMAX) begin
              s_hsel   <= '0;
              s_haddr  <= '0;
              s_hwrite <= 1'b0;
              state    <= ERR1;
            end
          end
        end
        ERR1: state <= ERR2;
        ERR2: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_matrix.sv
// Randomized bench for ahb_lite_matrix against a transaction-level
// model of arbitration, decode, wait states, errors and timeout.
module tb_ahb_lite_matrix;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn;
  logic [NM-1:0]    busreq;
  logic [NM-1:0]    valid;
  logic [NM-1:0]    wr;
  logic [31:0]      a_m [NM];
  logic [31:0]      d_m [NM];
  logic [NM*32-1:0] m_haddr;
  logic [NM*32-1:0] m_hwdata;
  logic [NM-1:0]    m_hgrant;
  logic [31:0]      m_hrdata;
  logic             m_hready;
  logic             m_hresp;
  logic [31:0]      s_haddr;
  logic             s_hwrite;
  logic [31:0]      s_hwdata;
  logic [NS-1:0]    s_hsel;
  logic [NS*32-1:0] s_hrdata;
  logic [NS-1:0]    s_hready;
  logic [NS-1:0]    s_hresp;

  assign m_haddr  = {a_m[1], a_m[0]};
  assign m_hwdata = {d_m[1], d_m[0]};

  always #5 clk = ~clk;

  ahb_lite_matrix #(
    .NUM_MASTERS(NM),
    .NUM_SLAVES (NS),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .SLV_BASE   ({32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK   ({32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .m_hbusreq(busreq),
    .m_hvalid (valid),
    .m_hwrite (wr),
    .m_haddr  (m_haddr),
    .m_hwdata (m_hwdata),
    .m_hgrant (m_hgrant),
    .m_hrdata (m_hrdata),
    .m_hready (m_hready),
    .m_hresp  (m_hresp),
    .s_haddr  (s_haddr),
    .s_hwrite (s_hwrite),
    .s_hwdata (s_hwdata),
    .s_hsel   (s_hsel),
    .s_hrdata (s_hrdata),
    .s_hready (s_hready),
    .s_hresp  (s_hresp)
  );

  int vec  = 0;
  int errs = 0;
  int last_win = NM - 1;

  logic [31:0] base_t [NS];
  logic [31:0] mask_t [NS];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NM-1:0] req);
    for (int k = 1; k <= NM; k++) begin
      int c;
      c = (last_win + k) % NM;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_t[i]) == base_t[i]) return i;
    return -1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, m_hgrant, 0);
    chk({tag, "_sel"}, s_hsel, 0);
    chk({tag, "_rdy"}, m_hready, 0);
    chk({tag, "_resp"}, m_hresp, 0);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic do_txn(input logic [NM-1:0] req, input int waits,
                        input logic [31:0] rdat, input logic rsp,
                        input int stall, input bit drop);
    int w;
    int s;
    int nw;
    logic [NS-1:0] esel;
    w = rr_pick(req);
    last_win = w;
    busreq = req;
    valid = (stall > 0) ? '0 : req;
    s_hready = '0;
    s_hresp = '0;
    s_hrdata = {$urandom, $urandom};
    @(negedge clk);
    chk("grant", m_hgrant, 64'(1) << w);
    chk("addr_rdy", m_hready, 0);
    if (drop) begin
      busreq = '0;
      valid = '0;
      @(negedge clk);
      chk_idle("drop");
      return;
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_grant", m_hgrant, 64'(1) << w);
      chk("stall_sel", s_hsel, 0);
    end
    valid = req;
    @(negedge clk);
    s = decode(a_m[w]);
    if (s < 0) begin
      chk("err1_sel", s_hsel, 0);
      chk("err1_rdy", m_hready, 0);
      chk("err1_resp", m_hresp, 1);
      busreq = '0;
      valid = '0;
      @(negedge clk);
      chk("err2_rdy", m_hready, 1);
      chk("err2_resp", m_hresp, 1);
      @(negedge clk);
      chk_idle("post_err");
      return;
    end
    esel = NS'(1) << s;
    nw = (waits >= TO) ? TO : waits;
    for (int k = 0; k < nw; k++) begin
      chk("wait_sel", s_hsel, esel);
      chk("wait_addr", s_haddr, a_m[w]);
      chk("wait_wdata", s_hwdata, d_m[w]);
      chk("wait_rdy", m_hready, 0);
      chk("wait_rdata", m_hrdata, s_hrdata[s*32 +: 32]);
      busreq = NM'($urandom);
      valid = NM'($urandom);
      s_hready = NS'($urandom) & ~esel;
      s_hresp = NS'($urandom);
      #1;
      chk("wait_rdy2", m_hready, 0);
      @(negedge clk);
    end
    if (waits >= TO) begin
      chk("to_sel", s_hsel, 0);
      chk("to_rdy", m_hready, 0);
      chk("to_resp", m_hresp, 1);
      busreq = '0;
      valid = '0;
      s_hready = '0;
      @(negedge clk);
      chk("to2_rdy", m_hready, 1);
      chk("to2_resp", m_hresp, 1);
      @(negedge clk);
      chk_idle("post_to");
      return;
    end
    s_hready = NS'($urandom) | esel;
    s_hresp = NS'($urandom);
    s_hresp[s] = rsp;
    s_hrdata[s*32 +: 32] = rdat;
    #1;
    chk("done_sel", s_hsel, esel);
    chk("done_addr", s_haddr, a_m[w]);
    chk("done_write", s_hwrite, wr[w]);
    chk("done_wdata", s_hwdata, d_m[w]);
    chk("done_rdy", m_hready, 1);
    chk("done_resp", m_hresp, rsp);
    chk("done_rdata", m_hrdata, rdat);
    busreq = '0;
    valid = '0;
    @(negedge clk);
    s_hready = '0;
    s_hresp = '0;
    chk_idle("post");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    a = $urandom;
    r = $urandom_range(0, 3);
    if (r == 0) a[31:28] = 4'h0;
    else if (r == 1) a[31:28] = 4'h1;
    else a[31:28] = 4'($urandom_range(2, 15));
    return a;
  endfunction

  initial begin
    base_t[0] = 32'h0000_0000;
    base_t[1] = 32'h1000_0000;
    mask_t[0] = 32'hF000_0000;
    mask_t[1] = 32'hF000_0000;
    rstn = 1'b0;
    busreq = '0;
    valid = '0;
    wr = '0;
    a_m[0] = '0;
    a_m[1] = '0;
    d_m[0] = '0;
    d_m[1] = '0;
    s_hrdata = '0;
    s_hready = '0;
    s_hresp = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_addr", s_haddr, 0);
    chk("reset_rdata", m_hrdata, 0);
    rstn = 1'b1;
    @(negedge clk);

    a_m[0] = 32'h0000_0040;
    d_m[0] = 32'hDEAD_BEEF;
    wr = 2'b01;
    do_txn(2'b01, 0, 32'h0, 1'b0, 0, 1'b0);

    a_m[1] = 32'h1000_0008;
    wr = 2'b00;
    do_txn(2'b10, 3, 32'h1234_5678, 1'b0, 0, 1'b0);

    for (int i = 0; i < 4; i++)
      do_txn(2'b11, 0, $urandom, 1'b0, 0, 1'b0);

    a_m[0] = 32'h2000_0000;
    do_txn(2'b01, 0, 32'h0, 1'b0, 0, 1'b0);

    a_m[0] = 32'h0000_0100;
    do_txn(2'b01, TO, 32'h0, 1'b0, 0, 1'b0);
    do_txn(2'b01, 1, 32'hCAFE_F00D, 1'b1, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      for (int m = 0; m < NM; m++) begin
        a_m[m] = rand_addr();
        d_m[m] = $urandom;
      end
      wr = NM'($urandom);
      do_txn(NM'($urandom_range(1, 3)),
             ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3),
             $urandom, ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
             ($urandom_range(0, 11) == 0));
    end

    a_m[0] = 32'h0000_0040;
    busreq = 2'b01;
    valid = 2'b01;
    s_hready = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sel", s_hsel, 2'b01);
    #2 rstn = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_addr", s_haddr, 0);
    chk("mid_rst_wr", s_hwrite, 0);
    chk("mid_rst_wdata", s_hwdata, 0);
    chk("mid_rst_rdata", m_hrdata, 0);
    busreq = '0;
    valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    last_win = NM - 1;
    @(negedge clk);
    do_txn(2'b11, 0, 32'h0BAD_CAFE, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
